// File: rtl/microwave_pkg.sv
// Shared types for the microwave timer and controller: BCD cook time, timer states, controller states.
// Pure package, no logic of its own; BCD time helpers are combinational.
package microwave_pkg;

    typedef logic [3:0] bcd_t;

    typedef struct packed {
        bcd_t m1;
        bcd_t m0;
        bcd_t s1;
        bcd_t s0;
    } cook_time_t;

    typedef enum logic [1:0] {IDLE, ARMED, RUN, DONE} timer_state_t;

    // Controller FSM encoding, kept here so the timer and controller agree on it.
    typedef enum logic [1:0] {CTRL_IDLE, CTRL_COOK, CTRL_BELL, CTRL_DOOR} ctrl_state_t;

    function automatic logic time_is_zero(input cook_time_t t);
        return (t == '0);
    endfunction

    // One-second BCD countdown; seconds are not range-limited, so 99 -> 98 is valid.
    function automatic cook_time_t time_dec(input cook_time_t t);
        cook_time_t r;
        r = t;
        if (t.s1 != 4'd0 || t.s0 != 4'd0) begin
            if (t.s0 == 4'd0) begin
                r.s1 = t.s1 - 4'd1;
                r.s0 = 4'd9;
            end else begin
                r.s0 = t.s0 - 4'd1;
            end
        end else begin
            r.s1 = 4'd5;
            r.s0 = 4'd9;
            if (t.m0 == 4'd0) begin
                r.m1 = t.m1 - 4'd1;
                r.m0 = 4'd9;
            end else begin
                r.m0 = t.m0 - 4'd1;
            end
        end
        return r;
    endfunction

    // +30 s with a single minute carry, saturating at 99:59.
    function automatic cook_time_t time_add30(input cook_time_t t);
        int sec;
        int mins;
        cook_time_t r;
        sec  = int'(t.s1) * 10 + int'(t.s0) + 30;
        mins = int'(t.m1) * 10 + int'(t.m0);
        if (sec > 59) begin
            sec  = sec - 60;
            mins = mins + 1;
        end
        if (mins > 99) begin
            r = '{m1: 4'd9, m0: 4'd9, s1: 4'd5, s0: 4'd9};
        end else begin
            r = '{m1: bcd_t'(mins / 10), m0: bcd_t'(mins % 10),
                  s1: bcd_t'(sec / 10),  s0: bcd_t'(sec % 10)};
        end
        return r;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Counts 0..N-1 while enabled and pulses tick on the wrap cycle; holds its value when disabled.
// clr zeroes the count synchronously and suppresses tick; no backpressure.
module tick_prescaler #(
    parameter int N = 50_000_000
) (
    input  logic clk,
    input  logic nrst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = $clog2(N);

    logic [W-1:0] cnt;

    assign tick = en && !clr && (cnt == W'(N - 1));

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == W'(N - 1)) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/microwave_timer.sv
// BCD MM:SS cook timer: keypad entry when idle, 1 Hz countdown in RUN, finish on 00:00; outputs one edge after inputs.
// Optional +30 s strobe via MICROWAVE_TIMER_ADD30_EN; clear overrides everything, no backpressure.
module microwave_timer
    import microwave_pkg::*;
#(
    parameter int CLK_PER_SEC = 50_000_000
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       heat,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       clear,
`ifdef MICROWAVE_TIMER_ADD30_EN
    input  logic       add30,
`endif
    output logic       finish,
    output logic       running,
    output logic       zero,
    output logic [3:0] disp_m1,
    output logic [3:0] disp_m0,
    output logic [3:0] disp_s1,
    output logic [3:0] disp_s0
);

    cook_time_t   tm;
    cook_time_t   t_entry;
    cook_time_t   t_run;
    timer_state_t st;
    logic         tick;

    tick_prescaler #(.N(CLK_PER_SEC)) u_prescaler (
        .clk  (clk),
        .nrst (nrst),
        .en   (st == RUN),
        .clr  (clear),
        .tick (tick)
    );

    // Candidate next times for the idle/armed and counting states.
    always_comb begin
        t_entry = tm;
        if (key_valid && key_digit <= 4'd9) begin
            t_entry = '{m1: tm.m0, m0: tm.s1, s1: tm.s0, s0: key_digit};
        end
        t_run = tick ? time_dec(tm) : tm;
`ifdef MICROWAVE_TIMER_ADD30_EN
        if (add30) begin
            t_entry = time_add30(tm);
            t_run   = time_add30(t_run);
        end
`endif
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            tm <= '0;
            st <= IDLE;
        end else if (clear) begin
            tm <= '0;
            st <= heat ? DONE : IDLE;
        end else begin
            case (st)
                IDLE, ARMED: begin
                    tm <= t_entry;
                    if (heat) st <= time_is_zero(t_entry) ? DONE : RUN;
                    else      st <= time_is_zero(t_entry) ? IDLE : ARMED;
                end
                RUN: begin
                    tm <= t_run;
                    if (time_is_zero(t_run)) st <= DONE;
                    else if (!heat)          st <= ARMED;
                end
                DONE: begin
                    if (!heat) st <= IDLE;
                end
            endcase
        end
    end

    assign finish  = (st == DONE);
    assign running = (st == RUN);
    assign zero    = time_is_zero(tm);
    assign disp_m1 = tm.m1;
    assign disp_m0 = tm.m0;
    assign disp_s1 = tm.s1;
    assign disp_s0 = tm.s0;

endmodule

// File: tb/tb_microwave_timer.sv
// Bench for microwave_timer at CLK_PER_SEC=4: directed vector table, async reset, then random traffic vs a seconds-level model.
module tb_microwave_timer;

    localparam int CPS     = 4;
    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_RUN   = 2;
    localparam int M_DONE  = 3;

    logic       clk       = 1'b0;
    logic       nrst      = 1'b0;
    logic       heat      = 1'b0;
    logic       key_valid = 1'b0;
    logic [3:0] key_digit = 4'd0;
    logic       clear     = 1'b0;
`ifdef MICROWAVE_TIMER_ADD30_EN
    logic       add30     = 1'b0;
`endif
    logic       finish, running, zero;
    logic [3:0] disp_m1, disp_m0, disp_s1, disp_s0;

    int n_chk  = 0;
    int n_pass = 0;

    microwave_timer #(.CLK_PER_SEC(CPS)) dut (
        .clk       (clk),
        .nrst      (nrst),
        .heat      (heat),
        .key_valid (key_valid),
        .key_digit (key_digit),
        .clear     (clear),
`ifdef MICROWAVE_TIMER_ADD30_EN
        .add30     (add30),
`endif
        .finish    (finish),
        .running   (running),
        .zero      (zero),
        .disp_m1   (disp_m1),
        .disp_m0   (disp_m0),
        .disp_s1   (disp_s1),
        .disp_s0   (disp_s0)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        h;
        logic        kv;
        logic [3:0]  kd;
        logic        clr;
        logic [15:0] t;
        logic        f;
        logic        r;
    } vec_t;

    vec_t vecs[$];

    // Reference model: digits, state and prescaler position as plain integers.
    int md[4];
    int mst;
    int mpre;

    task automatic add(input logic h, input logic kv, input logic [3:0] kd, input logic clr,
                       input logic [15:0] t, input logic f, input logic r, input int n = 1);
        vec_t v;
        v.h = h; v.kv = kv; v.kd = kd; v.clr = clr; v.t = t; v.f = f; v.r = r;
        repeat (n) vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [18:0] exp);
        logic [18:0] act;
        act = {disp_m1, disp_m0, disp_s1, disp_s0, finish, running, zero};
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got time=%h fin/run/zero=%b, want time=%h fin/run/zero=%b",
                      name, act[18:3], act[2:0], exp[18:3], exp[2:0]);
    endtask

    task automatic cyc(input logic h, input logic kv, input logic [3:0] kd, input logic clr);
        heat = h; key_valid = kv; key_digit = kd; clear = clr;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [18:0] exp_of(input logic [15:0] t, input logic f, input logic r);
        return {t, f, r, (t == 16'h0000)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) md[i] = 0;
        mst  = M_IDLE;
        mpre = 0;
    endtask

    task automatic model_step(input logic h, input logic kv, input logic [3:0] kd, input logic clr);
        int secs, mins;
        logic elapsed;
        if (clr) begin
            for (int i = 0; i < 4; i++) md[i] = 0;
            mpre = 0;
            mst  = h ? M_DONE : M_IDLE;
        end else if (mst == M_IDLE || mst == M_ARMED) begin
            if (kv && kd < 10) begin
                md[0] = md[1]; md[1] = md[2]; md[2] = md[3]; md[3] = int'(kd);
            end
            secs = md[0] * 1000 + md[1] * 100 + md[2] * 10 + md[3];
            if (h) mst = (secs != 0) ? M_RUN : M_DONE;
            else   mst = (secs != 0) ? M_ARMED : M_IDLE;
        end else if (mst == M_RUN) begin
            elapsed = (mpre == CPS - 1);
            mpre    = elapsed ? 0 : mpre + 1;
            mins    = md[0] * 10 + md[1];
            secs    = md[2] * 10 + md[3];
            if (elapsed) begin
                if (secs > 0) secs = secs - 1;
                else begin
                    mins = mins - 1;
                    secs = 59;
                end
                md[0] = mins / 10; md[1] = mins % 10; md[2] = secs / 10; md[3] = secs % 10;
            end
            if (mins == 0 && secs == 0) mst = M_DONE;
            else if (!h)                mst = M_ARMED;
        end else begin
            if (!h) mst = M_IDLE;
        end
    endtask

    function automatic logic [18:0] model_outs();
        logic [15:0] t;
        t = {4'(md[0]), 4'(md[1]), 4'(md[2]), 4'(md[3])};
        return exp_of(t, mst == M_DONE, mst == M_RUN);
    endfunction

    initial begin
        logic       h_r, kv_r, cl_r;
        logic [3:0] kd_r;

        // Keypad entry, invalid digit, clear.
        add(0, 1, 4'd1,  0, 16'h0001, 0, 0);
        add(0, 1, 4'd0,  0, 16'h0010, 0, 0);
        add(0, 1, 4'd5,  0, 16'h0105, 0, 0);
        add(0, 1, 4'd12, 0, 16'h0105, 0, 0);
        add(0, 0, 4'd0,  1, 16'h0000, 0, 0);
        // 00:02 countdown to finish, then heat drop.
        add(0, 1, 4'd2,  0, 16'h0002, 0, 0);
        add(1, 0, 4'd0,  0, 16'h0002, 0, 1, 4);
        add(1, 0, 4'd0,  0, 16'h0001, 0, 1, 4);
        add(1, 0, 4'd0,  0, 16'h0000, 1, 0, 2);
        add(0, 0, 4'd0,  0, 16'h0000, 0, 0);
        // Heat with 00:00 goes straight to DONE.
        add(1, 0, 4'd0,  0, 16'h0000, 1, 0);
        add(0, 0, 4'd0,  0, 16'h0000, 0, 0);
        // 01:00 -> 00:59 minute borrow.
        add(0, 1, 4'd1,  0, 16'h0001, 0, 0);
        add(0, 1, 4'd0,  0, 16'h0010, 0, 0);
        add(0, 1, 4'd0,  0, 16'h0100, 0, 0);
        add(1, 0, 4'd0,  0, 16'h0100, 0, 1, 4);
        add(1, 0, 4'd0,  0, 16'h0059, 0, 1);
        add(0, 0, 4'd0,  1, 16'h0000, 0, 0);
        // 00:99 -> 00:98, then clear while cooking ends in DONE.
        add(0, 1, 4'd9,  0, 16'h0009, 0, 0);
        add(0, 1, 4'd9,  0, 16'h0099, 0, 0);
        add(1, 0, 4'd0,  0, 16'h0099, 0, 1, 4);
        add(1, 0, 4'd0,  0, 16'h0098, 0, 1);
        add(1, 0, 4'd0,  1, 16'h0000, 1, 0);
        add(0, 0, 4'd0,  0, 16'h0000, 0, 0);
        // 00:10 -> 00:09 tens borrow.
        add(0, 1, 4'd1,  0, 16'h0001, 0, 0);
        add(0, 1, 4'd0,  0, 16'h0010, 0, 0);
        add(1, 0, 4'd0,  0, 16'h0010, 0, 1, 4);
        add(1, 0, 4'd0,  0, 16'h0009, 0, 1);
        add(0, 0, 4'd0,  1, 16'h0000, 0, 0);
        // Pause keeps the partial second: decrement two cycles after resume.
        add(0, 1, 4'd3,  0, 16'h0003, 0, 0);
        add(1, 0, 4'd0,  0, 16'h0003, 0, 1, 2);
        add(0, 0, 4'd0,  0, 16'h0003, 0, 0, 10);
        add(1, 0, 4'd0,  0, 16'h0003, 0, 1, 2);
        add(1, 0, 4'd0,  0, 16'h0002, 0, 1);
        // Clear at 00:40 in RUN; keys ignored in RUN and DONE.
        add(0, 0, 4'd0,  1, 16'h0000, 0, 0);
        add(0, 1, 4'd4,  0, 16'h0004, 0, 0);
        add(0, 1, 4'd0,  0, 16'h0040, 0, 0);
        add(1, 0, 4'd0,  0, 16'h0040, 0, 1);
        add(1, 1, 4'd7,  0, 16'h0040, 0, 1);
        add(1, 0, 4'd0,  1, 16'h0000, 1, 0);
        add(1, 1, 4'd7,  0, 16'h0000, 1, 0);
        add(0, 0, 4'd0,  0, 16'h0000, 0, 0);

        repeat (2) @(posedge clk);
        #1;
        check("reset", exp_of(16'h0000, 0, 0));
        nrst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cyc(vecs[i].h, vecs[i].kv, vecs[i].kd, vecs[i].clr);
            check($sformatf("vec%0d", i), exp_of(vecs[i].t, vecs[i].f, vecs[i].r));
        end

        // Asynchronous reset in the middle of a count.
        cyc(0, 1, 4'd5, 0);
        cyc(1, 0, 4'd0, 0);
        check("pre_async_run", exp_of(16'h0005, 0, 1));
        cyc(1, 0, 4'd0, 0);
        #2;
        nrst = 1'b0;
        #1;
        check("async_reset", exp_of(16'h0000, 0, 0));
        @(negedge clk);
        heat = 1'b0;
        nrst = 1'b1;
        model_reset();
        cyc(0, 0, 4'd0, 0);
        model_step(0, 0, 4'd0, 0);
        check("post_reset_idle", model_outs());

        h_r = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(23) == 0) h_r = ~h_r;
            kv_r = ($urandom_range(15) == 0);
            kd_r = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'($urandom_range(2));
            cl_r = ($urandom_range(59) == 0);
            cyc(h_r, kv_r, kd_r, cl_r);
            model_step(h_r, kv_r, kd_r, cl_r);
            check($sformatf("rand%0d", i), model_outs());
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
